// File: rtl/eth_arp_engine.sv
// eth_arp_engine
//    Single-clock ARP engine. Parses rx frames (post-SFD GMII bytes), learns
//    sender IP/MAC pairs into a small round-robin cache, answers ARP requests
//    for our IP with a 60-byte reply (framer adds preamble/FCS) and serves
//    registered, 1-cycle-latency cache lookups to the IP layer.
//
//    Ports
//       clk, rst_n                    clock, async active-low reset
//       i_cmd_addr/data/wr            config writes: 0x00 MAC[47:32], 0x01 MAC[31:0],
//                                     0x02 IP, 0x03 ctrl (b0 reply_en, b1 learn_en,
//                                     b2 cache clear pulse)
//       i_rx_data, i_rx_dv            rx byte stream, dst MAC first, FCS last
//       o_tx_data, o_tx_en            reply byte stream, dst MAC first
//       i_lookup_ip, i_lookup_req     cache lookup request
//       o_lookup_vld/hit/mac          lookup result, one cycle after request
//       o_irq_rx                      pulse per accepted ARP frame
//       o_rx_arp_cnt, o_drop_cnt      wrapping statistics
//
//    Build option: define ETH_ARP_FCS_CHECK_EN to require a valid CRC-32 FCS
//    and a 64-byte minimum frame before a frame is accepted.
//
//    Tx FSM states
//       state    | meaning
//       TX_IDLE  | nothing to send, waiting for a pending reply
//       TX_GAP   | inter-frame gap, IFG_CYC cycles of silence
//       TX_SEND  | driving the 60 reply bytes, index 0..59

module eth_arp_engine #(
   parameter int CACHE_DEPTH = 4,
   parameter int IFG_CYC     = 12,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       i_cmd_addr,
   input  logic [31:0]      i_cmd_data,
   input  logic             i_cmd_wr,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_dv,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_en,
   input  logic [31:0]      i_lookup_ip,
   input  logic             i_lookup_req,
   output logic             o_lookup_vld,
   output logic             o_lookup_hit,
   output logic [47:0]      o_lookup_mac,
   output logic             o_irq_rx,
   output logic [CNT_W-1:0] o_rx_arp_cnt,
   output logic [CNT_W-1:0] o_drop_cnt
);

   localparam int IDX_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
   localparam int GAP_W = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

   typedef enum logic [1:0] {TX_IDLE, TX_GAP, TX_SEND} tx_state_t;

   // ---------------------------------------------------------------- config
   logic [47:0] own_mac;
   logic [31:0] own_ip;
   logic        reply_en;
   logic        learn_en;
   logic        cache_clr;

   assign cache_clr = i_cmd_wr && (i_cmd_addr == 8'h03) && i_cmd_data[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_mac  <= '0;
         own_ip   <= '0;
         reply_en <= 1'b0;
         learn_en <= 1'b0;
      end else if (i_cmd_wr) begin
         case (i_cmd_addr)
            8'h00: own_mac[47:32] <= i_cmd_data[15:0];
            8'h01: own_mac[31:0]  <= i_cmd_data;
            8'h02: own_ip         <= i_cmd_data;
            8'h03: begin
               reply_en <= i_cmd_data[0];
               learn_en <= i_cmd_data[1];
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- rx parse
   logic [7:0]  rx_cnt;
   logic        rx_dv_d;
   logic        rx_armed;
   logic        dst_own;
   logic        dst_bc;
   logic        fix_ok;
   logic [7:0]  oper_lo;
   logic [47:0] rx_sha;
   logic [31:0] rx_spa;
   logic [31:0] rx_tpa;
   logic [7:0]  own_byte;
   logic [7:0]  fix_byte;
   logic        fix_chk;
   logic        rx_end;
   logic        fcs_ok;
   logic        rx_accept;

   // own MAC byte for the dst compare and the expected value of fixed header bytes
   always_comb begin
      own_byte = 8'h00;
      fix_byte = 8'h00;
      fix_chk  = 1'b0;
      case (rx_cnt)
         8'd0:  own_byte = own_mac[47:40];
         8'd1:  own_byte = own_mac[39:32];
         8'd2:  own_byte = own_mac[31:24];
         8'd3:  own_byte = own_mac[23:16];
         8'd4:  own_byte = own_mac[15:8];
         8'd5:  own_byte = own_mac[7:0];
         8'd12: begin fix_chk = 1'b1; fix_byte = 8'h08; end
         8'd13: begin fix_chk = 1'b1; fix_byte = 8'h06; end
         8'd14: begin fix_chk = 1'b1; fix_byte = 8'h00; end
         8'd15: begin fix_chk = 1'b1; fix_byte = 8'h01; end
         8'd16: begin fix_chk = 1'b1; fix_byte = 8'h08; end
         8'd17: begin fix_chk = 1'b1; fix_byte = 8'h00; end
         8'd18: begin fix_chk = 1'b1; fix_byte = 8'h06; end
         8'd19: begin fix_chk = 1'b1; fix_byte = 8'h04; end
         8'd20: begin fix_chk = 1'b1; fix_byte = 8'h00; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt   <= '0;
         rx_dv_d  <= 1'b0;
         rx_armed <= 1'b0;
         dst_own  <= 1'b0;
         dst_bc   <= 1'b0;
         fix_ok   <= 1'b0;
         oper_lo  <= '0;
         rx_sha   <= '0;
         rx_spa   <= '0;
         rx_tpa   <= '0;
      end else begin
         rx_dv_d <= i_rx_dv;
         // a frame already in flight when reset released is never accepted
         if (!i_rx_dv) rx_armed <= 1'b1;
         if (i_rx_dv) begin
            if (rx_cnt != 8'hFF) rx_cnt <= rx_cnt + 8'd1;
            if (rx_cnt == 8'd0) begin
               dst_own <= (i_rx_data == own_byte);
               dst_bc  <= (i_rx_data == 8'hFF);
               fix_ok  <= 1'b1;
            end else if (rx_cnt < 8'd6) begin
               dst_own <= dst_own && (i_rx_data == own_byte);
               dst_bc  <= dst_bc && (i_rx_data == 8'hFF);
            end
            if (fix_chk && (i_rx_data != fix_byte)) fix_ok <= 1'b0;
            if (rx_cnt == 8'd21) oper_lo <= i_rx_data;
            if (rx_cnt >= 8'd22 && rx_cnt <= 8'd27) rx_sha <= {rx_sha[39:0], i_rx_data};
            if (rx_cnt >= 8'd28 && rx_cnt <= 8'd31) rx_spa <= {rx_spa[23:0], i_rx_data};
            if (rx_cnt >= 8'd38 && rx_cnt <= 8'd41) rx_tpa <= {rx_tpa[23:0], i_rx_data};
         end else begin
            rx_cnt <= '0;
         end
      end
   end

`ifdef ETH_ARP_FCS_CHECK_EN
   logic [31:0] rx_crc;

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int b = 0; b < 32; b++) r[b] = v[31-b];
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_crc <= '1;
      end else if (i_rx_dv) begin
         rx_crc <= crc_next((rx_cnt == 8'd0) ? 32'hFFFF_FFFF : rx_crc, i_rx_data);
      end
   end

   // reflected register holds the bit-reversed form of the residue
   assign fcs_ok = (rx_cnt >= 8'd64) && (bit_rev(rx_crc) == 32'hC704_DD7B);
`else
   assign fcs_ok = 1'b1;
`endif

   assign rx_end    = rx_dv_d && !i_rx_dv;
   assign rx_accept = rx_end && rx_armed && fcs_ok && (rx_cnt >= 8'd42) && fix_ok &&
                      ((oper_lo == 8'd1) || (oper_lo == 8'd2)) && (dst_own || dst_bc);

   // ---------------------------------------------------------------- cache
   logic             cache_vld [CACHE_DEPTH];
   logic [31:0]      cache_ip  [CACHE_DEPTH];
   logic [47:0]      cache_mac [CACHE_DEPTH];
   logic [IDX_W-1:0] rr;
   logic             learn_hit;
   logic [IDX_W-1:0] learn_idx;
   logic             lk_hit;
   logic [47:0]      lk_mac;
   logic             do_learn;

   always_comb begin
      learn_hit = 1'b0;
      learn_idx = rr;
      lk_hit    = 1'b0;
      lk_mac    = '0;
      for (int i = 0; i < CACHE_DEPTH; i++) begin
         if (cache_vld[i] && (cache_ip[i] == rx_spa) && !learn_hit) begin
            learn_hit = 1'b1;
            learn_idx = IDX_W'(i);
         end
         if (cache_vld[i] && (cache_ip[i] == i_lookup_ip) && !lk_hit) begin
            lk_hit = 1'b1;
            lk_mac = cache_mac[i];
         end
      end
   end

   assign do_learn = rx_accept && learn_en && (rx_spa != 32'h0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= '0;
         for (int i = 0; i < CACHE_DEPTH; i++) begin
            cache_vld[i] <= 1'b0;
            cache_ip[i]  <= '0;
            cache_mac[i] <= '0;
         end
      end else if (cache_clr) begin
         rr <= '0;
         for (int i = 0; i < CACHE_DEPTH; i++) cache_vld[i] <= 1'b0;
      end else if (do_learn) begin
         cache_vld[learn_idx] <= 1'b1;
         cache_ip[learn_idx]  <= rx_spa;
         cache_mac[learn_idx] <= rx_sha;
         if (!learn_hit) rr <= (rr == IDX_W'(CACHE_DEPTH - 1)) ? '0 : rr + 1'b1;
      end
   end

   // lookup reads pre-edge contents, so a same-cycle learn is not visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_lookup_vld <= 1'b0;
         o_lookup_hit <= 1'b0;
         o_lookup_mac <= '0;
      end else begin
         o_lookup_vld <= i_lookup_req;
         o_lookup_hit <= i_lookup_req && lk_hit;
         o_lookup_mac <= i_lookup_req ? lk_mac : 48'h0;
      end
   end

   // ---------------------------------------------------------------- reply / stats
   tx_state_t        tx_state;
   tx_state_t        tx_next;
   logic [GAP_W-1:0] gap_cnt;
   logic [5:0]       byte_idx;
   logic             pending;
   logic [47:0]      rep_sha;
   logic [31:0]      rep_spa;
   logic             is_req;
   logic             tx_busy;
   logic             enter_send;

   assign is_req     = rx_accept && (oper_lo == 8'd1) && (rx_tpa == own_ip) && reply_en;
   assign tx_busy    = pending || (tx_state != TX_IDLE);
   assign enter_send = (tx_state == TX_GAP) && (tx_next == TX_SEND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_irq_rx     <= 1'b0;
         o_rx_arp_cnt <= '0;
         o_drop_cnt   <= '0;
         pending      <= 1'b0;
         rep_sha      <= '0;
         rep_spa      <= '0;
      end else begin
         o_irq_rx <= rx_accept;
         if (rx_accept) o_rx_arp_cnt <= o_rx_arp_cnt + CNT_W'(1);
         if (enter_send) pending <= 1'b0;
         if (is_req) begin
            if (tx_busy) begin
               o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            end else begin
               pending <= 1'b1;
               rep_sha <= rx_sha;
               rep_spa <= rx_spa;
            end
         end
      end
   end

   // ---------------------------------------------------------------- tx FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         gap_cnt  <= '0;
         byte_idx <= '0;
      end else begin
         tx_state <= tx_next;
         case (tx_state)
            TX_IDLE: begin
               gap_cnt  <= GAP_W'(IFG_CYC - 1);
               byte_idx <= '0;
            end
            TX_GAP:  if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            TX_SEND: byte_idx <= byte_idx + 6'd1;
            default: ;
         endcase
      end
   end

   // own MAC/IP are read live so config changes show up on the very next byte
   logic [479:0] tx_frame;
   logic [479:0] tx_shift;

   assign tx_frame = {rep_sha, own_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                      16'h0002, own_mac, own_ip, rep_sha, rep_spa, 144'h0};
   assign tx_shift = tx_frame << {byte_idx, 3'b000};

   always_comb begin
      tx_next   = tx_state;
      o_tx_en   = 1'b0;
      o_tx_data = 8'h00;
      case (tx_state)
         TX_IDLE: if (pending) tx_next = TX_GAP;
         TX_GAP:  if (gap_cnt == '0) tx_next = TX_SEND;
         TX_SEND: begin
            o_tx_en   = 1'b1;
            o_tx_data = tx_shift[479:472];
            if (byte_idx == 6'd59) tx_next = TX_IDLE;
         end
         default: tx_next = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_eth_arp_engine.sv
// tb_eth_arp_engine
//    Directed bench for eth_arp_engine: reply generation and timing, learning,
//    lookup hit/miss, round-robin eviction, drop on busy tx, frame rejection,
//    and reset during a reply.

module tb_eth_arp_engine;

   localparam int CACHE_DEPTH = 4;
   localparam int IFG_CYC     = 12;
   localparam int CNT_W       = 8;

   localparam logic [47:0] OWN_MAC = 48'h020A_0B0C_0D0E;
   localparam logic [31:0] OWN_IP  = 32'hC0A8_010A;
   localparam logic [47:0] BC_MAC  = 48'hFFFF_FFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       i_cmd_addr = '0;
   logic [31:0]      i_cmd_data = '0;
   logic             i_cmd_wr = 1'b0;
   logic [7:0]       i_rx_data = '0;
   logic             i_rx_dv = 1'b0;
   logic [7:0]       o_tx_data;
   logic             o_tx_en;
   logic [31:0]      i_lookup_ip = '0;
   logic             i_lookup_req = 1'b0;
   logic             o_lookup_vld;
   logic             o_lookup_hit;
   logic [47:0]      o_lookup_mac;
   logic             o_irq_rx;
   logic [CNT_W-1:0] o_rx_arp_cnt;
   logic [CNT_W-1:0] o_drop_cnt;

   eth_arp_engine #(.CACHE_DEPTH(CACHE_DEPTH), .IFG_CYC(IFG_CYC), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmd_addr   (i_cmd_addr),
      .i_cmd_data   (i_cmd_data),
      .i_cmd_wr     (i_cmd_wr),
      .i_rx_data    (i_rx_data),
      .i_rx_dv      (i_rx_dv),
      .o_tx_data    (o_tx_data),
      .o_tx_en      (o_tx_en),
      .i_lookup_ip  (i_lookup_ip),
      .i_lookup_req (i_lookup_req),
      .o_lookup_vld (o_lookup_vld),
      .o_lookup_hit (o_lookup_hit),
      .o_lookup_mac (o_lookup_mac),
      .o_irq_rx     (o_irq_rx),
      .o_rx_arp_cnt (o_rx_arp_cnt),
      .o_drop_cnt   (o_drop_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   int         cyc = 0;
   int         irq_cnt = 0;
   int         irq_cyc = 0;
   int         tx_frames = 0;
   int         tx_start_cyc = 0;
   int         tx_pos = 0;
   int         last_len = 0;
   int         idle_bad = 0;
   logic       tx_en_d = 1'b0;
   logic [7:0] tx_buf [60];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (o_tx_en) begin
         if (!tx_en_d) begin
            tx_pos = 0;
            tx_frames++;
            tx_start_cyc = cyc;
         end
         if (tx_pos < 60) tx_buf[tx_pos] = o_tx_data;
         tx_pos++;
      end else begin
         if (tx_en_d) last_len = tx_pos;
         if (o_tx_data != 8'h00) idle_bad++;
      end
      tx_en_d = o_tx_en;
      if (o_irq_rx) begin
         irq_cnt++;
         irq_cyc = cyc;
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   logic [7:0] fr [64];
   logic [7:0] exp_tx [60];

   task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                        input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
      logic [511:0] v;
      v = {dst, sha, etype, 16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa, 48'h0, tpa, 176'h0};
      for (int i = 0; i < 64; i++) fr[i] = v[511-8*i -: 8];
   endtask

   task automatic build_reply(input logic [47:0] sha, input logic [31:0] spa);
      logic [479:0] e;
      e = {sha, OWN_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
           OWN_MAC, OWN_IP, sha, spa, 144'h0};
      for (int i = 0; i < 60; i++) exp_tx[i] = e[479-8*i -: 8];
   endtask

   task automatic send(input int len);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         i_rx_dv   = 1'b1;
         i_rx_data = fr[i];
      end
      @(posedge clk); #1;
      i_rx_dv   = 1'b0;
      i_rx_data = 8'h00;
      repeat (3) @(posedge clk);
   endtask

   task automatic cfg(input logic [7:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      i_cmd_addr = addr;
      i_cmd_data = data;
      i_cmd_wr   = 1'b1;
      @(posedge clk); #1;
      i_cmd_wr   = 1'b0;
   endtask

   task automatic lk(input string tag, input logic [31:0] ip, input logic exp_hit,
                     input logic [47:0] exp_mac);
      @(posedge clk); #1;
      i_lookup_ip  = ip;
      i_lookup_req = 1'b1;
      @(posedge clk); #1;
      i_lookup_req = 1'b0;
      chk({tag, "_vld"}, {63'h0, o_lookup_vld}, 64'h1);
      chk({tag, "_hit"}, {63'h0, o_lookup_hit}, {63'h0, exp_hit});
      chk({tag, "_mac"}, {16'h0, o_lookup_mac}, {16'h0, exp_mac});
   endtask

   task automatic wait_tx(input string tag, input int target);
      for (int k = 0; k < 300; k++) begin
         if (tx_frames >= target) break;
         @(negedge clk);
      end
      chk(tag, 64'(tx_frames), 64'(target));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   // ---------------------------------------------------------------- test sequence
   initial begin
      logic [47:0] sha1, sha2, sha3, sha4, sha5;
      logic [31:0] spa1, spa2, spa3, spa4, spa5;

      sha1 = 48'h0200_0000_00AA; spa1 = 32'hC0A8_0114;
      sha2 = 48'h0200_0000_0005; spa2 = 32'h0A00_0005;
      sha3 = 48'h0200_0000_00B3; spa3 = 32'hC0A8_0115;
      sha4 = 48'h0200_0000_00B4; spa4 = 32'hC0A8_0116;
      sha5 = 48'h0200_0000_00B5; spa5 = 32'hC0A8_0117;

      repeat (3) @(posedge clk); #1;
      chk("rst_tx_en",   {63'h0, o_tx_en}, 64'h0);
      chk("rst_tx_data", {56'h0, o_tx_data}, 64'h0);
      chk("rst_irq",     {63'h0, o_irq_rx}, 64'h0);
      chk("rst_lk_vld",  {63'h0, o_lookup_vld}, 64'h0);
      chk("rst_rx_cnt",  64'(o_rx_arp_cnt), 64'h0);
      chk("rst_drop",    64'(o_drop_cnt), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      cfg(8'h00, 32'h0000_020A);
      cfg(8'h01, 32'h0B0C_0D0E);
      cfg(8'h02, OWN_IP);
      cfg(8'h03, 32'h0000_0003);

      // broadcast request for our IP -> reply after the gap
      build(BC_MAC, 16'h0806, 16'h0001, sha1, spa1, OWN_IP);
      send(46);
      chk("req_irq_cnt", 64'(irq_cnt), 64'd1);
      chk("req_rx_cnt",  64'(o_rx_arp_cnt), 64'd1);
      wait_tx("req_tx_start", 1);
      // pending is set with the irq edge, IDLE->GAP takes one more edge
      chk("req_gap_lat", 64'(tx_start_cyc - irq_cyc), 64'(IFG_CYC + 1));
      repeat (70) @(negedge clk);
      chk("req_tx_len", 64'(last_len), 64'd60);
      build_reply(sha1, spa1);
      for (int i = 0; i < 60; i++) chk($sformatf("req_tx_byte%0d", i), 64'(tx_buf[i]), 64'(exp_tx[i]));
      chk("req_drop", 64'(o_drop_cnt), 64'h0);
      lk("lk_req_sender", spa1, 1'b1, sha1);

      // unicast reply, exactly 42 bytes, learned
      build(OWN_MAC, 16'h0806, 16'h0002, sha2, spa2, OWN_IP);
      send(42);
      chk("rep_rx_cnt", 64'(o_rx_arp_cnt), 64'd2);
      lk("lk_10_0_0_5", spa2, 1'b1, sha2);
      lk("lk_10_0_0_6", 32'h0A00_0006, 1'b0, 48'h0);

      // rejected frames
      build(BC_MAC, 16'h0800, 16'h0001, 48'h0200_0000_00CC, 32'h0A00_00AA, OWN_IP);
      send(46);
      build(48'h020A_0B0C_0D0F, 16'h0806, 16'h0001, 48'h0200_0000_00CC, 32'h0A00_00AA, OWN_IP);
      send(46);
      build(BC_MAC, 16'h0806, 16'h0001, 48'h0200_0000_00CC, 32'h0A00_00AA, OWN_IP);
      send(41);
      build(BC_MAC, 16'h0806, 16'h0003, 48'h0200_0000_00CC, 32'h0A00_00AA, OWN_IP);
      send(46);
      repeat (40) @(negedge clk);
      chk("rej_rx_cnt",  64'(o_rx_arp_cnt), 64'd2);
      chk("rej_irq_cnt", 64'(irq_cnt), 64'd2);
      chk("rej_tx",      64'(tx_frames), 64'd1);
      lk("lk_rejected", 32'h0A00_00AA, 1'b0, 48'h0);

      // clear, then CACHE_DEPTH+1 senders: first evicted
      cfg(8'h03, 32'h0000_0007);
      lk("lk_after_clear", spa2, 1'b0, 48'h0);
      for (int k = 1; k <= 5; k++) begin
         build(BC_MAC, 16'h0806, 16'h0002, 48'h0200_0001_0000 + 48'(k), 32'h0A00_0100 + 32'(k), 32'h0A00_00FE);
         send(46);
      end
      lk("lk_evict_1", 32'h0A00_0101, 1'b0, 48'h0);
      for (int k = 2; k <= 5; k++)
         lk($sformatf("lk_keep_%0d", k), 32'h0A00_0100 + 32'(k), 1'b1, 48'h0200_0001_0000 + 48'(k));
      // rr wrapped to 1: the sixth sender lands on slot 1 (sender 2)
      build(BC_MAC, 16'h0806, 16'h0002, 48'h0200_0001_0006, 32'h0A00_0106, 32'h0A00_00FE);
      send(46);
      lk("lk_evict_2", 32'h0A00_0102, 1'b0, 48'h0);
      lk("lk_new_6",   32'h0A00_0106, 1'b1, 48'h0200_0001_0006);
      // known sender with a new MAC: overwrite in place, no eviction
      build(BC_MAC, 16'h0806, 16'h0002, 48'h0200_0000_BEEF, 32'h0A00_0103, 32'h0A00_00FE);
      send(46);
      lk("lk_overwrite_3", 32'h0A00_0103, 1'b1, 48'h0200_0000_BEEF);
      lk("lk_keep_4b",     32'h0A00_0104, 1'b1, 48'h0200_0001_0004);
      lk("lk_keep_5b",     32'h0A00_0105, 1'b1, 48'h0200_0001_0005);
      chk("evict_rx_cnt", 64'(o_rx_arp_cnt), 64'd9);

      // second request while the first reply is on the wire -> dropped
      build(BC_MAC, 16'h0806, 16'h0001, sha3, spa3, OWN_IP);
      send(46);
      wait_tx("b2b_tx_start", 2);
      build(BC_MAC, 16'h0806, 16'h0001, sha4, spa4, OWN_IP);
      send(46);
      chk("b2b_drop", 64'(o_drop_cnt), 64'd1);
      repeat (150) @(negedge clk);
      chk("b2b_frames", 64'(tx_frames), 64'd2);
      chk("b2b_len",    64'(last_len), 64'd60);
      chk("b2b_dst",    {16'h0, tx_buf[0], tx_buf[1], tx_buf[2], tx_buf[3], tx_buf[4], tx_buf[5]},
                        {16'h0, sha3});
      chk("b2b_rx_cnt", 64'(o_rx_arp_cnt), 64'd11);

      // async reset while sending
      build(BC_MAC, 16'h0806, 16'h0001, sha5, spa5, OWN_IP);
      send(46);
      wait_tx("rst_tx_start", 3);
      repeat (5) @(negedge clk);
      chk("pre_rst_tx_en", {63'h0, o_tx_en}, 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx_en", {63'h0, o_tx_en}, 64'h0);
      chk("rst_mid_cnt",   64'(o_rx_arp_cnt), 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      lk("lk_post_rst_5",  spa5, 1'b0, 48'h0);
      lk("lk_post_rst_6",  32'h0A00_0106, 1'b0, 48'h0);
      repeat (20) @(negedge clk);
      chk("post_rst_tx", 64'(tx_frames), 64'd3);
      chk("idle_data_zero", 64'(idle_bad), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
